// File: rtl/cunit_pkg.sv
// Shared opcode, state and ALU-select encodings for the parametrised lab-processor control unit.
package cunit_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_JZ    = 4'd7;

  localparam logic [2:0] ALU_NOP    = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_PASS_A = 3'd3;

  // Encodings are visible on StateO, so they are fixed explicitly.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_JMP    = 4'd10,
    S_JZ     = 4'd11
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/cunit_gen_if.sv
// Instruction-memory fetch handshake between the control unit (master) and instruction memory (slave).
interface cunit_gen_if #(
  parameter int PC_W = 8,
  parameter int IW   = 16
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic [IW-1:0]   data;
  logic            valid;

  modport master (output req, output addr, input data, input valid);
  modport slave  (input req, input addr, output data, output valid);
endinterface

// File: rtl/cunit_gen_pc_load_counter.sv
// Program counter: async clear, increment, parallel load; load has priority over increment.
module pc_load_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] count
);

  localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Counter register; the increment wraps naturally at 2^PC_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cunit_gen.sv
// Multi-cycle control unit: fetch over a req/valid handshake, decode, and Moore-decoded datapath controls.
// Parameters are expected to satisfy PC_W <= 2*RA_W and DA_W <= 2*RA_W.
module cunit_gen
  import cunit_pkg::*;
#(
  parameter int  PC_W = 8,
  parameter int  RA_W = 4,
  parameter int  DA_W = 8,
  localparam int IW   = 4 + 3*RA_W
) (
  input  logic             Clock,
  input  logic             Reset,
  cunit_gen_if.master      imem,
  input  logic             Alu_zero,
  output logic [DA_W-1:0]  D_addr,
  output logic             D_wr,
  output logic             RF_s,
  output logic [RA_W-1:0]  RF_W_addr,
  output logic [RA_W-1:0]  RF_Ra_addr,
  output logic [RA_W-1:0]  RF_Rb_addr,
  output logic             RF_W_wr,
  output logic             RF_Ra_rd,
  output logic             RF_Rb_rd,
  output logic [2:0]       Alu_s0,
  output logic [PC_W-1:0]  PC_Out,
  output logic [IW-1:0]    IR_Out,
  output logic [3:0]       StateO,
  output logic             Halted,
  output logic             Illegal
);

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   ir;
  logic [PC_W-1:0] pc;
  logic            fetch_accept;
  logic            pc_load;
  logic [3:0]      op;
  logic [RA_W-1:0] f1;
  logic [RA_W-1:0] f2;
  logic [RA_W-1:0] f3;
  logic [DA_W-1:0] ld_addr;
  logic [DA_W-1:0] st_addr;
  logic [PC_W-1:0] target;

  assign op      = ir[IW-1 -: 4];
  assign f1      = ir[IW-5 -: RA_W];
  assign f2      = ir[IW-5-RA_W -: RA_W];
  assign f3      = ir[RA_W-1:0];
  assign ld_addr = ir[IW-5 -: DA_W];
  assign st_addr = ir[DA_W-1:0];
  assign target  = ir[PC_W-1:0];

  assign fetch_accept = (state == S_FETCH) && imem.valid;
  // Jump targets override the increment already applied at fetch accept.
  assign pc_load      = (state == S_JMP) || ((state == S_JZ) && Alu_zero);

  pc_load_counter #(.PC_W(PC_W)) u_pc (
    .clk      (Clock),
    .rst      (Reset),
    .inc      (fetch_accept),
    .load     (pc_load),
    .load_val (target),
    .count    (pc)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Instruction register, captured only on an accepted fetch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ir <= '0;
    end else if (fetch_accept) begin
      ir <= imem.data;
    end else begin
      ir <= ir;
    end
  end

  assign imem.addr = pc;
  assign PC_Out    = pc;
  assign IR_Out    = ir;
  assign StateO    = state;

  // Next-state logic and per-state control decode from registered state and IR.
  always_comb begin
    state_nx   = state;
    imem.req   = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    RF_W_wr    = 1'b0;
    RF_Ra_rd   = 1'b0;
    RF_Rb_rd   = 1'b0;
    Alu_s0     = ALU_NOP;
    Halted     = 1'b0;
    Illegal    = 1'b0;
    case (state)
      S_INIT: state_nx = S_FETCH;
      S_FETCH: begin
        imem.req = 1'b1;
        if (imem.valid) begin
          state_nx = S_DECODE;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op)
          OP_NOOP:  state_nx = S_NOOP;
          OP_STORE: state_nx = S_STORE;
          OP_LOAD:  state_nx = S_LOAD_A;
          OP_ADD:   state_nx = S_ADD;
          OP_SUB:   state_nx = S_SUB;
          OP_HALT:  state_nx = S_HALT;
          OP_JMP:   state_nx = S_JMP;
          OP_JZ:    state_nx = S_JZ;
          default:  state_nx = S_NOOP;
        endcase
        Illegal = !op_is_legal(op);
      end
      S_NOOP: state_nx = S_FETCH;
      S_LOAD_A: begin
        D_addr   = ld_addr;
        state_nx = S_LOAD_B;
      end
      S_LOAD_B: begin
        D_addr    = ld_addr;
        RF_s      = 1'b1;
        RF_W_wr   = 1'b1;
        RF_W_addr = f3;
        state_nx  = S_FETCH;
      end
      S_STORE: begin
        D_addr     = st_addr;
        D_wr       = 1'b1;
        RF_Ra_rd   = 1'b1;
        RF_Ra_addr = f1;
        state_nx   = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_rd   = 1'b1;
        RF_Rb_rd   = 1'b1;
        RF_Ra_addr = f1;
        RF_Rb_addr = f2;
        Alu_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        RF_W_wr    = 1'b1;
        RF_W_addr  = f3;
        state_nx   = S_FETCH;
      end
      S_HALT: begin
        Halted   = 1'b1;
        state_nx = S_HALT;
      end
      S_JMP: state_nx = S_FETCH;
      S_JZ: begin
        RF_Ra_rd   = 1'b1;
        RF_Ra_addr = f1;
        Alu_s0     = ALU_PASS_A;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_cunit_gen.sv
// Scoreboard bench for cunit_gen: an ISA-level model predicts each instruction's controls at fetch time.
module tb_cunit_gen;
  import cunit_pkg::*;

  localparam int PC_W = 8;
  localparam int RA_W = 4;
  localparam int DA_W = 8;
  localparam int IW   = 16;

  typedef struct {
    logic [3:0]  st;
    logic [28:0] ctrl;
    logic        ill;
    logic [15:0] ir;
    logic [7:0]  npc;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Alu_zero = 1'b0;
  logic [DA_W-1:0] D_addr;
  logic D_wr, RF_s, RF_W_wr, RF_Ra_rd, RF_Rb_rd, Halted, Illegal;
  logic [RA_W-1:0] RF_W_addr, RF_Ra_addr, RF_Rb_addr;
  logic [2:0] Alu_s0;
  logic [PC_W-1:0] PC_Out;
  logic [IW-1:0] IR_Out;
  logic [3:0] StateO;
  logic [28:0] obs_ctrl;

  cunit_gen_if #(.PC_W(PC_W), .IW(IW)) bus();

  cunit_gen #(.PC_W(PC_W), .RA_W(RA_W), .DA_W(DA_W)) dut (
    .Clock(Clock), .Reset(Reset), .imem(bus), .Alu_zero(Alu_zero),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
    .RF_W_wr(RF_W_wr), .RF_Ra_rd(RF_Ra_rd), .RF_Rb_rd(RF_Rb_rd),
    .Alu_s0(Alu_s0), .PC_Out(PC_Out), .IR_Out(IR_Out), .StateO(StateO),
    .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  assign obs_ctrl = {D_addr, D_wr, RF_s, RF_W_addr, RF_Ra_addr, RF_Rb_addr,
                     RF_W_wr, RF_Ra_rd, RF_Rb_rd, Alu_s0, Halted};

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] mem [256];
  exp_t sb[$];
  logic [3:0] trace[$];
  logic [3:0] trace_exp [17] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd1, 4'd2, 4'd4, 4'd5,
                                 4'd1, 4'd2, 4'd7, 4'd1, 4'd2, 4'd6, 4'd1, 4'd2, 4'd9};
  logic [7:0]  model_pc;
  logic [15:0] model_ir;
  logic [7:0]  pend_pc;
  logic        pc_pending, ill_latch, tracing, noise, rand_delay;
  logic [3:0]  prev_st;
  int wait_cnt, cur_delay, fetch_delay, fetch_run, exp_fetch_len, ill_cycles;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model of one instruction: executing state, controls, illegal flag, next PC.
  function automatic exp_t build_exp(input logic [15:0] ir, input logic [7:0] pc1, input logic az);
    exp_t e;
    logic [7:0] da;
    logic [3:0] wa, raa, rba;
    logic dwr, rfs, wwr, rar, rbr, hlt;
    logic [2:0] alu;
    da = 8'd0; wa = 4'd0; raa = 4'd0; rba = 4'd0;
    dwr = 1'b0; rfs = 1'b0; wwr = 1'b0; rar = 1'b0; rbr = 1'b0; hlt = 1'b0; alu = 3'd0;
    e.st = 4'd3; e.ill = 1'b0; e.ir = ir; e.npc = pc1;
    case (ir[15:12])
      4'd0: e.st = 4'd3;
      4'd1: begin e.st = 4'd6; da = ir[7:0]; dwr = 1'b1; rar = 1'b1; raa = ir[11:8]; end
      4'd2: begin e.st = 4'd5; da = ir[11:4]; rfs = 1'b1; wwr = 1'b1; wa = ir[3:0]; end
      4'd3, 4'd4: begin
        e.st = (ir[15:12] == 4'd3) ? 4'd7 : 4'd8;
        raa = ir[11:8]; rba = ir[7:4]; wa = ir[3:0];
        rar = 1'b1; rbr = 1'b1; wwr = 1'b1;
        alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
      end
      4'd5: begin e.st = 4'd9; hlt = 1'b1; end
      4'd6: begin e.st = 4'd10; e.npc = ir[7:0]; end
      4'd7: begin e.st = 4'd11; rar = 1'b1; raa = ir[11:8]; alu = 3'd3; e.npc = az ? ir[7:0] : pc1; end
      default: begin e.st = 4'd3; e.ill = 1'b1; end
    endcase
    e.ctrl = {da, dwr, rfs, wa, raa, rba, wwr, rar, rbr, alu, hlt};
    return e;
  endfunction

  task automatic monitor();
    logic [3:0] st;
    exp_t e;
    st = StateO;
    if (Illegal) ill_cycles++;
    if (tracing) trace.push_back(st);
    if (pc_pending) begin
      check_val("pc_after_exec", PC_Out, pend_pc);
      pc_pending = 1'b0;
    end
    if (st == 4'd1) begin
      fetch_run++;
      check_val("fetch_addr", bus.addr, model_pc);
      check_val("ir_hold", IR_Out, model_ir);
    end else if (st == 4'd2) begin
      if (exp_fetch_len >= 0) check_val("fetch_len", fetch_run, exp_fetch_len);
      fetch_run = 0;
      ill_latch = Illegal;
      check_val("decode_quiet", obs_ctrl, 0);
    end else if (st != 4'd0 && st != 4'd4 && !(st == 4'd9 && prev_st == 4'd9)) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("exec_state", st, e.st);
        check_val("exec_ctrl", obs_ctrl, e.ctrl);
        check_val("illegal", ill_latch, e.ill);
        check_val("exec_ir", IR_Out, e.ir);
        pc_pending = 1'b1;
        pend_pc = e.npc;
      end
    end
    prev_st = st;
  endtask

  task automatic drive();
    exp_t e;
    if (bus.req) begin
      if (wait_cnt < cur_delay) begin
        bus.valid = 1'b0;
        bus.data = 16'($urandom);
        wait_cnt++;
      end else begin
        check_val("accept_addr", bus.addr, model_pc);
        bus.valid = 1'b1;
        bus.data = mem[model_pc];
        e = build_exp(mem[model_pc], model_pc + 8'd1, Alu_zero);
        sb.push_back(e);
        model_ir = mem[model_pc];
        model_pc = e.npc;
        wait_cnt = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, 2)) : fetch_delay;
      end
    end else begin
      bus.valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.data = 16'($urandom);
    end
  endtask

  task automatic step();
    @(negedge Clock);
    monitor();
    drive();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.valid = 1'b0;
    sb.delete();
    pc_pending = 1'b0; ill_latch = 1'b0;
    model_pc = 8'd0; model_ir = 16'd0;
    wait_cnt = 0; cur_delay = fetch_delay; fetch_run = 0; ill_cycles = 0;
    prev_st = 4'd0;
    repeat (2) @(negedge Clock);
    check_val("rst_state", StateO, 0);
    check_val("rst_pc", PC_Out, 0);
    check_val("rst_ir", IR_Out, 0);
    check_val("rst_req", bus.req, 0);
    check_val("rst_ctrl", {obs_ctrl, Illegal}, 0);
    Reset = 1'b0;
  endtask

  task automatic run_until_halt(input int budget);
    int n;
    n = 0;
    while (n < budget && StateO != 4'd9) begin
      step();
      n++;
    end
    check_val("reach_halt", StateO, 9);
    repeat (2) step();
  endtask

  task automatic run_until_state(input logic [3:0] s, input int budget);
    int n;
    n = 0;
    while (n < budget && StateO != s) begin
      step();
      n++;
    end
    check_val("reach_state", StateO, s);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.data = 16'h0000;
    tracing = 1'b0; noise = 1'b0; rand_delay = 1'b0;
    fetch_delay = 0; exp_fetch_len = 1;

    // Zero-wait LOAD/LOAD/ADD/STORE/HALT program with full state trace.
    clear_mem();
    mem[0] = 16'h2051; mem[1] = 16'h2062; mem[2] = 16'h3123; mem[3] = 16'h1307; mem[4] = 16'h5000;
    do_reset();
    tracing = 1'b1;
    run_until_halt(100);
    tracing = 1'b0;
    check_val("trace_len", trace.size() >= 17, 1);
    for (int i = 0; i < 17; i++) begin
      if (i < trace.size()) check_val($sformatf("trace_%0d", i), trace[i], trace_exp[i]);
    end
    check_val("halted", Halted, 1);
    check_val("halt_pc", PC_Out, 5);

    // Fetch with valid delayed three cycles.
    clear_mem();
    mem[1] = 16'h5000;
    fetch_delay = 3; exp_fetch_len = 4;
    do_reset();
    run_until_halt(100);
    check_val("delay_halt_pc", PC_Out, 2);

    // JZ taken, with valid noise outside FETCH.
    clear_mem();
    mem[0] = 16'h7420; mem[8'h20] = 16'h5000;
    fetch_delay = 0; exp_fetch_len = 1; noise = 1'b1; Alu_zero = 1'b1;
    do_reset();
    run_until_halt(100);
    check_val("jz_taken_pc", PC_Out, 8'h21);

    // JZ not taken, then SUB, with random fetch latency.
    clear_mem();
    mem[0] = 16'h7420; mem[1] = 16'h4675; mem[2] = 16'h5000;
    Alu_zero = 1'b0; rand_delay = 1'b1; exp_fetch_len = -1;
    do_reset();
    run_until_halt(200);
    check_val("jz_fall_pc", PC_Out, 3);
    rand_delay = 1'b0; noise = 1'b0; exp_fetch_len = 1;

    // Illegal opcode pulses once and behaves as NOOP.
    clear_mem();
    mem[0] = 16'hF123; mem[1] = 16'h5000;
    do_reset();
    run_until_halt(100);
    check_val("illegal_cycles", ill_cycles, 1);
    check_val("illegal_pc", PC_Out, 2);

    // PC wrap: plain fetch at 0xFF, then JMP from 0xFF to 0.
    clear_mem();
    mem[0] = 16'h60FF;
    do_reset();
    repeat (20) step();
    mem[8'hFF] = 16'h6000;
    do_reset();
    repeat (20) step();

    // Reset during LOAD_B.
    clear_mem();
    mem[0] = 16'h2051;
    do_reset();
    run_until_state(4'd5, 20);
    Reset = 1'b1;
    #1;
    check_val("rstb_wr", RF_W_wr, 0);
    check_val("rstb_state", StateO, 0);
    check_val("rstb_pc", PC_Out, 0);
    check_val("rstb_ir", IR_Out, 0);

    // Reset during FETCH while valid is high.
    do_reset();
    step();
    check_val("rstf_req_pre", {bus.req, bus.valid}, 2'b11);
    Reset = 1'b1;
    #1;
    check_val("rstf_req", bus.req, 0);
    check_val("rstf_pc", PC_Out, 0);
    @(posedge Clock);
    #1;
    check_val("rstf_ir", IR_Out, 0);
    check_val("rstf_pc_hold", PC_Out, 0);
    bus.valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cunit_gen.md
# cunit_gen

Parametrised, multi-cycle control unit for the lab processor: fetches instructions from an external instruction memory over a request/valid handshake, decodes them, and drives the register-file, data-RAM and ALU control lines of the datapath. Generalises the fixed-width control unit with configurable PC, register-address and data-address widths, variable-latency fetch, unconditional and conditional jumps, illegal-opcode flagging, and a halted indication.

## Interface
- PC_W, 8, program counter and instruction-address width; must satisfy PC_W <= 2*RA_W
- RA_W, 4, register-file address width
- DA_W, 8, data-RAM address width; must satisfy DA_W <= 2*RA_W
- IW, derived = 4 + 3*RA_W, instruction width (16 at defaults); not overridable
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high
- Imem_req  out  1  fetch request, held high in FETCH until accepted
- Imem_addr  out  PC_W  fetch address, equals PC_Out
- Imem_data  in  IW  instruction word, sampled when Imem_req && Imem_valid
- Imem_valid  in  1  fetch data valid
- Alu_zero  in  1  datapath ALU result is zero, combinational from Ra
- D_addr  out  DA_W  data-RAM address
- D_wr  out  1  data-RAM write enable
- RF_s  out  1  RF write-data mux select: 1 = RAM, 0 = ALU
- RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  RA_W each  RF write / read-A / read-B addresses
- RF_W_wr, RF_Ra_rd, RF_Rb_rd  out  1 each  RF write / read-A / read-B enables
- Alu_s0  out  3  ALU function select
- PC_Out  out  PC_W  current PC; IR_Out  out  IW  current instruction
- StateO  out  4  current state encoding
- Halted  out  1  high in HALT; Illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- Fields: op = IR[IW-1:IW-4]; F1 = next RA_W bits down, F2 = next RA_W, F3 = low RA_W.
- Opcodes: NOOP 0; STORE 1 (Ra=F1, addr=IR[DA_W-1:0]); LOAD 2 (addr=IR[IW-5 -: DA_W], Rd=F3); ADD 3 / SUB 4 (Ra=F1, Rb=F2, Rd=F3); HALT 5; JMP 6 (target=IR[PC_W-1:0]); JZ 7 (Ra=F1, target=IR[PC_W-1:0]); 8-15 illegal.
- States/StateO: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9, JMP 10, JZ 11.
- INIT -> FETCH unconditionally.
- FETCH: Imem_req=1; on Imem_valid, IR <= Imem_data, PC <= PC+1 (mod 2^PC_W), -> DECODE; else stay.
- DECODE: no outputs asserted; -> state selected by op; illegal -> NOOP with Illegal=1 that cycle.
- NOOP -> FETCH.
- LOAD_A: D_addr driven -> LOAD_B: D_addr held, RF_s=1, RF_W_wr=1, RF_W_addr=Rd -> FETCH.
- STORE: D_addr, D_wr=1, RF_Ra_rd=1, RF_Ra_addr=Ra -> FETCH.
- ADD/SUB: Ra/Rb read enables, Alu_s0 = ALU_ADD(1)/ALU_SUB(2), RF_s=0, RF_W_wr=1, RF_W_addr=Rd -> FETCH.
- JMP: PC <= target -> FETCH.
- JZ: RF_Ra_rd=1, Alu_s0=ALU_PASS_A(3); at cycle end PC <= target if Alu_zero else unchanged -> FETCH.
- HALT: Halted=1, all enables 0, terminal until Reset.
- Outputs not listed for a state are 0; all control outputs decode from registered state and IR (Moore, glitch-free per state).

## Timing
- Reset: state INIT, PC=0, IR=0, every output 0 (Imem_addr=0, StateO=0).
- Reset mid-fetch or mid-instruction: request dropped immediately, no RAM/RF write completes after assertion.
- Instruction latency = fetch cycles (>=1) + DECODE 1 + execute (LOAD 2, others 1); zero-wait memory: NOOP 3 cycles, LOAD 4.
- Imem_valid outside FETCH ignored; Imem_data must be valid in the same cycle as Imem_valid.
- PC increments at fetch accept, so JMP/JZ targets override the incremented value; PC=2^PC_W-1 wraps to 0.
- JZ to own address with Ra=0 loops indefinitely (legal).

## Structure
- Package cunit_pkg: opcode constants, state enum with fixed StateO encodings, ALU select codes (NOP 0, ADD 1, SUB 2, PASS_A 3).
- One sub-module: pc_load_counter #(PC_W) with async clear, increment, parallel load (load wins over increment).
- FSM, IR and output decode live in cunit_gen.

## Test plan
- Reset then zero-wait program {LOAD R1<-D[5], LOAD R2<-D[6], ADD R3=R1+R2, STORE D[7]<-R3, HALT} -> StateO 0,1,2,4,5,1,2,4,5,1,2,7,1,2,6,1,2,9; Halted=1; PC_Out=5.
- Fetch with Imem_valid delayed 3 cycles -> FETCH held 4 cycles, Imem_addr stable, IR unchanged until valid.
- JZ R4, 0x20 with Alu_zero=1 -> PC_Out=0x20 next FETCH; with Alu_zero=0 -> PC_Out=old PC+1.
- Opcode 0xF -> Illegal pulse exactly one cycle, no enables asserted, next FETCH at PC+1; JMP from PC=0xFF with target 0 and plain fetch at 0xFF -> PC wraps to 0.
- Reset asserted during LOAD_B and during FETCH with Imem_valid high -> RF_W_wr and Imem_req drop same cycle, PC=0, IR=0.
